init_sequencer: RTL and testbench

- Power-on and retry sequencer that sits directly upstream of the system initialization controller.
- Waits for PLL lock and a power-up settling delay, then holds the init controller in reset for a fixed number of cycles.
- Pulses start to the init controller and supervises its done flag against a timeout, retrying up to a bounded count.
- Drives the system-wide ready and fail flags consumed by the capture/display datapath.

---
 rtl/init_seq_pkg.sv | 27 ++
 rtl/init_sequencer_if.sv | 13 +
 rtl/sync_2ff.sv | 25 ++
 rtl/init_sequencer.sv | 169 ++++++++++++++++
 tb/tb_init_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/init_seq_pkg.sv
// Shared definitions for the init sequencer: state encodings (also used as
// the state_dbg value), default timing constants for the top level and its
// benches, and a terminal-count helper.
package init_seq_pkg;

  // state_dbg encodings; any other value is treated as S_WAIT_LOCK
  localparam logic [2:0] S_WAIT_LOCK = 3'd0;
  localparam logic [2:0] S_PWRUP     = 3'd1;
  localparam logic [2:0] S_SUB_RST   = 3'd2;
  localparam logic [2:0] S_START     = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_READY     = 3'd5;
  localparam logic [2:0] S_FAIL      = 3'd6;

  localparam logic [23:0] PWRUP_DELAY_DEF    = 24'd1_000_000;
  localparam logic [7:0]  SUB_RST_CYCLES_DEF = 8'd16;
  localparam logic [27:0] INIT_TIMEOUT_DEF   = 28'd100_000_000;
  localparam logic [2:0]  MAX_RETRIES_DEF    = 3'd3;
  localparam logic [23:0] HB_DIV_DEF         = 24'd12_500_000;

  // The shared counter starts at 0 on state entry, so a phase of n cycles
  // ends when the counter shows n-1.
  function automatic logic [27:0] term_count(input logic [27:0] n);
    return n - 28'd1;
  endfunction

endpackage

// File: rtl/init_sequencer_if.sv
// Handshake between the init sequencer and the downstream init controller.
//   init_rst_n : active-low reset to the init controller
//   init_start : one-cycle start pulse
//   init_done  : sticky done level, cleared only by init_rst_n
// master = sequencer side, slave = init controller side.
interface init_sequencer_if;
  logic init_rst_n;
  logic init_start;
  logic init_done;

  modport master (output init_rst_n, output init_start, input init_done);
  modport slave  (input init_rst_n, input init_start, output init_done);
endinterface

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous status inputs.
//   clk   : destination clock
//   reset : synchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output (2 cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/init_sequencer.sv
// Power-on / retry sequencer in front of the system init controller.
// Waits for PLL lock and a settling delay, holds the init controller in
// reset, pulses start, supervises done against a timeout, and retries a
// bounded number of times before declaring failure.
//
// Ports:
//   clk        : system clock
//   reset      : synchronous active-low reset
//   pll_locked : asynchronous PLL lock (synchronized internally)
//   init_if    : master side of the init controller handshake
//   sys_ready  : system initialized and PLL locked
//   init_fail  : sticky, all attempts exhausted
//   attempt    : attempts started, saturating at MAX_RETRIES+1
//   state_dbg  : current state encoding
//   heartbeat  : status blink, present only with INIT_SEQ_HEARTBEAT_EN
//
// Optional feature macro: INIT_SEQ_HEARTBEAT_EN
//
// state       | meaning
// S_WAIT_LOCK | waiting for synchronized PLL lock, controller held in reset
// S_PWRUP     | rail settling delay after lock
// S_SUB_RST   | controller reset held low before an attempt
// S_START     | start pulse cycle
// S_WAIT_DONE | waiting for done, timeout running
// S_READY     | system initialized
// S_FAIL      | all attempts exhausted, terminal until reset
//
// Outputs are registered from the current state, so each lags the state
// by one cycle; lock_s gates them so lock loss drops them without waiting
// for the state change.
module init_sequencer
  import init_seq_pkg::*;
#(
  parameter logic [23:0] PWRUP_DELAY    = PWRUP_DELAY_DEF,
  parameter logic [7:0]  SUB_RST_CYCLES = SUB_RST_CYCLES_DEF,
  parameter logic [27:0] INIT_TIMEOUT   = INIT_TIMEOUT_DEF,
  parameter logic [2:0]  MAX_RETRIES    = MAX_RETRIES_DEF
`ifdef INIT_SEQ_HEARTBEAT_EN
  ,
  parameter logic [23:0] HB_DIV         = HB_DIV_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pll_locked,
  init_sequencer_if.master init_if,
  output logic             sys_ready,
  output logic             init_fail,
  output logic [2:0]       attempt,
  output logic [2:0]       state_dbg
`ifdef INIT_SEQ_HEARTBEAT_EN
  ,
  output logic             heartbeat
`endif
);

  localparam logic [27:0] PWRUP_TC = term_count(28'(PWRUP_DELAY));
  localparam logic [27:0] SUB_TC   = term_count(28'(SUB_RST_CYCLES));
  localparam logic [27:0] TO_TC    = term_count(INIT_TIMEOUT);

  logic        lock_s;
  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [27:0] cnt;
  logic        init_rst_n_q;
  logic        init_start_q;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_comb begin
    state_nxt = state;
    if (!lock_s && state != S_FAIL) begin
      state_nxt = S_WAIT_LOCK;
    end else begin
      case (state)
        S_WAIT_LOCK: state_nxt = S_PWRUP;
        S_PWRUP:     if (cnt == PWRUP_TC) state_nxt = S_SUB_RST;
        S_SUB_RST:   if (cnt == SUB_TC) state_nxt = S_START;
        S_START:     state_nxt = S_WAIT_DONE;
        S_WAIT_DONE: begin
          // done takes priority over a timeout in the same cycle
          if (init_if.init_done) begin
            state_nxt = S_READY;
          end else if (cnt == TO_TC) begin
            state_nxt = (attempt <= MAX_RETRIES) ? S_SUB_RST : S_FAIL;
          end
        end
        S_READY:     state_nxt = S_READY;
        S_FAIL:      state_nxt = S_FAIL;
        default:     state_nxt = S_WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_WAIT_LOCK;
      cnt          <= '0;
      attempt      <= '0;
      init_rst_n_q <= 1'b0;
      init_start_q <= 1'b0;
      sys_ready    <= 1'b0;
      init_fail    <= 1'b0;
    end else begin
      state <= state_nxt;

      // counter only runs in timed states, so idle states never wrap it
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (state == S_PWRUP || state == S_SUB_RST || state == S_WAIT_DONE) begin
        cnt <= cnt + 28'd1;
      end

      if (!lock_s && state != S_FAIL) begin
        attempt <= '0;
      end else if (state_nxt == S_SUB_RST && state != S_SUB_RST) begin
        if (attempt <= MAX_RETRIES) attempt <= attempt + 3'd1;
      end

      init_start_q <= lock_s && (state == S_START);
      init_rst_n_q <= lock_s && (state == S_START || state == S_WAIT_DONE ||
                                 state == S_READY);
      sys_ready    <= lock_s && (state == S_READY);
      if (state == S_FAIL) init_fail <= 1'b1;
    end
  end

  assign init_if.init_rst_n = init_rst_n_q;
  assign init_if.init_start = init_start_q;
  assign state_dbg          = state;

`ifdef INIT_SEQ_HEARTBEAT_EN
  logic [23:0] hb_cnt;
  logic [23:0] hb_tc;
  logic        hb_run;

  // slow blink when ready, fast blink while sequencing, steady otherwise
  always_comb begin
    hb_run = 1'b1;
    hb_tc  = HB_DIV - 24'd1;
    case (state)
      S_READY:             hb_tc  = HB_DIV - 24'd1;
      S_WAIT_LOCK, S_FAIL: hb_run = 1'b0;
      default:             hb_tc  = (HB_DIV >> 3) - 24'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else if (!hb_run) begin
      hb_cnt    <= '0;
      heartbeat <= (state == S_FAIL);
    end else if (hb_cnt >= hb_tc) begin
      hb_cnt    <= '0;
      heartbeat <= ~heartbeat;
    end else begin
      hb_cnt    <= hb_cnt + 24'd1;
    end
  end
`endif

endmodule

// File: tb/tb_init_sequencer.sv
// Self-checking bench for init_sequencer. Expected start-pulse cycles are
// queued when lock/reset stimulus is applied and checked when pulses
// appear; a small init-controller model raises done per queued plan.
module tb_init_sequencer;
  import init_seq_pkg::*;

  localparam logic [23:0] T_PWRUP = 24'd10;
  localparam logic [7:0]  T_SUB   = 8'd4;
  localparam logic [27:0] T_TO    = 28'd50;
  localparam logic [2:0]  T_MR    = 3'd2;
  // 2 sync flops, then delay + reset + 2 cycles to the registered start
  localparam int START_LAT = 2 + int'(T_PWRUP) + int'(T_SUB) + 2;
  localparam int RETRY_GAP = int'(T_TO) + int'(T_SUB) + 1;

  logic       clk;
  logic       reset;
  logic       pll_locked;
  logic       sys_ready;
  logic       init_fail;
  logic [2:0] attempt;
  logic [2:0] state_dbg;
`ifdef INIT_SEQ_HEARTBEAT_EN
  logic       heartbeat;
`endif

  init_sequencer_if sif ();

  init_sequencer #(
    .PWRUP_DELAY    (T_PWRUP),
    .SUB_RST_CYCLES (T_SUB),
    .INIT_TIMEOUT   (T_TO),
    .MAX_RETRIES    (T_MR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .init_if    (sif),
    .sys_ready  (sys_ready),
    .init_fail  (init_fail),
    .attempt    (attempt),
    .state_dbg  (state_dbg)
`ifdef INIT_SEQ_HEARTBEAT_EN
    ,
    .heartbeat  (heartbeat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_start[$];
  int plan[$];
  int done_delay = -1;
  int done_cnt = 0;
  int done_cyc = 0;
  int rst_low_run = 0;
  int start_rst_low = 0;
  bit armed = 1'b0;

  task automatic step();
    int e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (sif.init_start === 1'b1) begin
      checks++;
      if (exp_start.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected pulse at cycle %0d, none expected", cyc);
      end else begin
        e = exp_start.pop_front();
        if (cyc !== e) begin
          errors++;
          $display("FAIL start_cycle got cycle %0d, required %0d", cyc, e);
        end
      end
      checks++;
      if (sif.init_rst_n !== 1'b1) begin
        errors++;
        $display("FAIL start_in_reset init_rst_n=%b, required 1", sif.init_rst_n);
      end
      start_rst_low = rst_low_run;
      done_delay = (plan.size() != 0) ? plan.pop_front() : -1;
      done_cnt = 0;
      armed = (done_delay > 0);
    end else if (armed) begin
      done_cnt++;
      if (done_cnt == done_delay) begin
        sif.init_done = 1'b1;
        done_cyc = cyc;
        armed = 1'b0;
      end
    end
    if (sif.init_rst_n !== 1'b1) begin
      rst_low_run++;
      sif.init_done = 1'b0;
      armed = 1'b0;
    end else begin
      rst_low_run = 0;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    pll_locked = 1'b0;
    steps(2);
    reset = 1'b1;
    steps(2);
    exp_start.delete();
    plan.delete();
    armed = 1'b0;
  endtask

  task automatic lock_and_expect(input int n_starts);
    pll_locked = 1'b1;
    for (int i = 0; i < n_starts; i++)
      exp_start.push_back(cyc + START_LAT + i * RETRY_GAP);
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int n = 0;
    while (sys_ready !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (sys_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout sys_ready=%b after %0d cycles, required 1", tag, sys_ready, budget);
    end else begin
      checks++;
      if (cyc - done_cyc !== 2) begin
        errors++;
        $display("FAIL %s_ready_latency got %0d cycles, required 2", tag, cyc - done_cyc);
      end
    end
    checks++;
    if (exp_start.size() !== 0) begin
      errors++;
      $display("FAIL %s_missing_starts got %0d pending, required 0", tag, exp_start.size());
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (sif.init_rst_n !== 1'b0 || sif.init_start !== 1'b0 || sys_ready !== 1'b0 ||
        init_fail !== 1'b0 || attempt !== 3'd0 || state_dbg !== S_WAIT_LOCK) begin
      errors++;
      $display("FAIL %s rst_n=%b start=%b ready=%b fail=%b attempt=%0d state=%0d, required 0 0 0 0 0 0",
               tag, sif.init_rst_n, sif.init_start, sys_ready, init_fail, attempt, state_dbg);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pll_locked = 1'b1;
    steps(3);
    check_idle("reset_values");
    reset = 1'b1;
    pll_locked = 1'b0;
    steps(6);
    check_idle("unlocked_idle");
  endtask

  task automatic test_nominal();
    plan.push_back(20);
    lock_and_expect(1);
    wait_ready(100, "nominal");
    checks++;
    if (attempt !== 3'd1 || sif.init_rst_n !== 1'b1 || state_dbg !== S_READY) begin
      errors++;
      $display("FAIL nominal_status attempt=%0d rst_n=%b state=%0d, required 1 1 %0d",
               attempt, sif.init_rst_n, state_dbg, S_READY);
    end
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    steps(3);
    check_idle("lock_loss");
    plan.push_back(20);
    lock_and_expect(1);
    wait_ready(100, "relock");
    checks++;
    if (attempt !== 3'd1) begin
      errors++;
      $display("FAIL relock_attempt got %0d, required 1", attempt);
    end
  endtask

  task automatic test_one_timeout();
    apply_reset();
    plan.push_back(-1);
    plan.push_back(5);
    lock_and_expect(2);
    wait_ready(250, "retry");
    checks++;
    if (attempt !== 3'd2) begin
      errors++;
      $display("FAIL retry_attempt got %0d, required 2", attempt);
    end
    checks++;
    if (start_rst_low !== int'(T_SUB)) begin
      errors++;
      $display("FAIL retry_rst_width got %0d cycles, required %0d", start_rst_low, T_SUB);
    end
  endtask

  task automatic test_timeout_tie();
    apply_reset();
    plan.push_back(int'(T_TO) - 1);
    lock_and_expect(1);
    wait_ready(150, "tie");
    steps(70);
    checks++;
    if (attempt !== 3'd1 || sys_ready !== 1'b1 || state_dbg !== S_READY) begin
      errors++;
      $display("FAIL tie_status attempt=%0d ready=%b state=%0d, required 1 1 %0d",
               attempt, sys_ready, state_dbg, S_READY);
    end
  endtask

  task automatic test_exhaustion();
    int n = 0;
    int fail_exp;
    apply_reset();
    plan.push_back(-1);
    plan.push_back(-1);
    plan.push_back(-1);
    fail_exp = cyc + START_LAT + 2 * RETRY_GAP + int'(T_TO) + 1;
    lock_and_expect(3);
    while (init_fail !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (init_fail !== 1'b1 || cyc !== fail_exp) begin
      errors++;
      $display("FAIL exhaust_fail init_fail=%b at cycle %0d, required 1 at %0d", init_fail, cyc, fail_exp);
    end
    steps(30);
    checks++;
    if (exp_start.size() !== 0) begin
      errors++;
      $display("FAIL exhaust_starts got %0d pending, required 0", exp_start.size());
    end
    checks++;
    if (sif.init_rst_n !== 1'b0 || attempt !== 3'd3 || sys_ready !== 1'b0 || state_dbg !== S_FAIL) begin
      errors++;
      $display("FAIL exhaust_status rst_n=%b attempt=%0d ready=%b state=%0d, required 0 3 0 %0d",
               sif.init_rst_n, attempt, sys_ready, state_dbg, S_FAIL);
    end
    pll_locked = 1'b0;
    steps(6);
    checks++;
    if (init_fail !== 1'b1 || state_dbg !== S_FAIL || attempt !== 3'd3) begin
      errors++;
      $display("FAIL fail_sticky fail=%b state=%0d attempt=%0d, required 1 %0d 3",
               init_fail, state_dbg, attempt, S_FAIL);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    apply_reset();
    plan.push_back(-1);
    lock_and_expect(1);
    while (exp_start.size() != 0 && n < 60) begin
      step();
      n++;
    end
    steps(10);
    checks++;
    if (state_dbg !== S_WAIT_DONE) begin
      errors++;
      $display("FAIL midwait_state got %0d, required %0d", state_dbg, S_WAIT_DONE);
    end
    reset = 1'b0;
    step();
    check_idle("reset_mid_wait");
    reset = 1'b1;
    exp_start.delete();
    plan.push_back(20);
    lock_and_expect(1);
    wait_ready(100, "after_reset");
    checks++;
    if (attempt !== 3'd1) begin
      errors++;
      $display("FAIL after_reset_attempt got %0d, required 1", attempt);
    end
  endtask

  initial begin
    reset = 1'b0;
    pll_locked = 1'b0;
    sif.init_done = 1'b0;
    test_reset();
    test_nominal();
    test_lock_loss();
    test_one_timeout();
    test_timeout_tie();
    test_exhaustion();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
